// File: rtl/mul_div_unit.sv
// Multiply/divide unit holding the architectural HI/LO registers with configurable latencies.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
`endif
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  logic [CNT_W-1:0]   count_q, count_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;

  logic               signed_op;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   num_mag, den_mag, den_safe, uq, ur, quot, rem;
  logic               a_neg, b_neg;
  logic               res_we;
  logic [WIDTH-1:0]   res_hi, res_lo;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_sum, acc_dif;
`endif

  function automatic logic is_launch_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_launch_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_launch_op = 1'b1;
`endif
      default: is_launch_op = 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] latency_of(input logic [3:0] op);
    case (op)
      OP_DIV, OP_DIVU: latency_of = CNT_W'(DIV_CYCLES);
      default:         latency_of = CNT_W'(MUL_CYCLES);
    endcase
  endfunction

  // Result datapath: one 2W multiplier on sign/zero-extended operands plus a magnitude divider.
  always_comb begin
    case (op_q)
      OP_MULT: signed_op = 1'b1;
      OP_DIV:  signed_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD: signed_op = 1'b1;
      OP_MSUB: signed_op = 1'b1;
`endif
      default: signed_op = 1'b0;
    endcase

    ext_a = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;

    a_neg    = signed_op & a_q[WIDTH-1];
    b_neg    = signed_op & b_q[WIDTH-1];
    num_mag  = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    den_mag  = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    // A zero divisor never commits; substituting 1 keeps the divider free of X/undefined results.
    den_safe = (den_mag == '0) ? WIDTH'(1) : den_mag;
    uq       = num_mag / den_safe;
    ur       = num_mag % den_safe;
    quot     = (a_neg ^ b_neg) ? (~uq + WIDTH'(1)) : uq;
    rem      = a_neg ? (~ur + WIDTH'(1)) : ur;

`ifdef MDU_MADD_EN
    acc_sum = {hi_q, lo_q} + prod;
    acc_dif = {hi_q, lo_q} - prod;
`endif

    res_we = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_we = 1'b1;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
      OP_DIV, OP_DIVU: begin
        res_we = (b_q != '0);
        res_hi = rem;
        res_lo = quot;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        res_we = 1'b1;
        res_hi = acc_sum[2*WIDTH-1:WIDTH];
        res_lo = acc_sum[WIDTH-1:0];
      end
      OP_MSUB, OP_MSUBU: begin
        res_we = 1'b1;
        res_hi = acc_dif[2*WIDTH-1:WIDTH];
        res_lo = acc_dif[WIDTH-1:0];
      end
`endif
      default: begin
        res_we = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
      end
    endcase
  end

  // Sequencing: cancel beats everything, then the in-flight countdown, then launch or mthi/mtlo.
  always_comb begin
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (cancel) begin
      count_d = '0;
      op_d    = OP_NONE;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
      if ((count_q == CNT_W'(1)) && res_we) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else if (start && is_launch_op(MDUOp)) begin
      count_d = latency_of(MDUOp);
      op_d    = MDUOp;
      a_d     = A;
      b_d     = B;
    end else if (MDUOp == OP_MTHI) begin
      hi_d = A;
    end else if (MDUOp == OP_MTLO) begin
      lo_d = A;
    end else begin
      count_d = '0;
    end

    busy_d = (count_d != '0);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign busy = busy_q;

endmodule
